lvds_link_ctrl: RTL and testbench

CLKP-domain bring-up and supervision controller for one LVDS serdes lane. It drives the lane's CLR, INV and PATTERN controls and watches the lane's ERR_CNT/RECV_CNT. It trains the link with the PRBS payload (PATTERN=0), searching both receive polarities, and retries until the link is error-free or the retry budget is spent. Once up, it monitors the error rate and retrains automatically on degradation.

---
 rtl/lvds_link_ctrl.sv | 164 ++++++++++++++++
 tb/tb_lvds_link_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_link_ctrl.sv
// Bring-up and supervision FSM for one LVDS serdes lane: trains with PRBS over
// both receive polarities, retries a bounded number of sweeps, retrains on error growth.
module lvds_link_ctrl #(
  parameter int unsigned CLR_CYC     = 16,
  parameter int unsigned SETTLE_CYC  = 1024,
  parameter int unsigned MIN_RECV    = 4096,
  parameter int unsigned TIMEOUT_CYC = 65536,
  parameter int unsigned MAX_RETRY   = 4,
  parameter int unsigned ERR_THRESH  = 8
) (
  input  logic        RSTXP,
  input  logic        CLKP,
  input  logic        START,
  input  logic        STOP,
  input  logic [1:0]  PAT_SEL,
  input  logic [63:0] ERR_CNT,
  input  logic [57:0] RECV_CNT,
  output logic        CLR,
  output logic        INV,
  output logic [1:0]  PATTERN,
  output logic        LINK_UP,
  output logic        LINK_FAIL,
  output logic [2:0]  STATE,
  output logic [3:0]  RETRY_CNT,
  output logic [15:0] RETRAIN_CNT
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_SETTLE  = 3'd2,
    S_MEASURE = 3'd3,
    S_EVAL    = 3'd4,
    S_UP      = 3'd5,
    S_FAIL    = 3'd6
  } state_t;

  state_t      st;
  logic [31:0] tmr;
  logic [63:0] e0, e1;
  logic [57:0] r0;
  logic        pass_q;

  // Modular deltas: counter wrap between snapshot and use needs no special case.
  logic [57:0] d_r;
  logic [63:0] d_e, d_up;
  logic [3:0]  retry_nx;
  logic        recv_ok;

  assign d_r      = RECV_CNT - r0;
  assign d_e      = ERR_CNT - e0;
  assign d_up     = ERR_CNT - e1;
  assign recv_ok  = d_r >= 58'(MIN_RECV);
  assign retry_nx = RETRY_CNT + 4'd1;
  assign STATE    = st;

  always_ff @(posedge CLKP or negedge RSTXP) begin
    if (!RSTXP) begin
      st          <= S_IDLE;
      tmr         <= '0;
      e0          <= '0;
      e1          <= '0;
      r0          <= '0;
      pass_q      <= 1'b0;
      CLR         <= 1'b1;
      INV         <= 1'b0;
      PATTERN     <= 2'd0;
      LINK_UP     <= 1'b0;
      LINK_FAIL   <= 1'b0;
      RETRY_CNT   <= '0;
      RETRAIN_CNT <= '0;
    end else if (STOP) begin
      st        <= S_IDLE;
      tmr       <= '0;
      CLR       <= 1'b1;
      PATTERN   <= 2'd0;
      LINK_UP   <= 1'b0;
      LINK_FAIL <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          CLR     <= 1'b1;
          PATTERN <= 2'd0;
          if (START) begin
            st        <= S_CLEAR;
            tmr       <= '0;
            INV       <= 1'b0;
            RETRY_CNT <= '0;
          end
        end
        S_CLEAR: begin
          CLR <= 1'b1;
          if (tmr >= 32'(CLR_CYC - 1)) begin
            st  <= S_SETTLE;
            CLR <= 1'b0;
            tmr <= '0;
          end else tmr <= tmr + 32'd1;
        end
        S_SETTLE: begin
          if (tmr >= 32'(SETTLE_CYC - 1)) begin
            e0  <= ERR_CNT;
            r0  <= RECV_CNT;
            st  <= S_MEASURE;
            tmr <= '0;
          end else tmr <= tmr + 32'd1;
        end
        S_MEASURE: begin
          if (recv_ok || tmr >= 32'(TIMEOUT_CYC - 1)) begin
            pass_q <= recv_ok && (d_e == 64'd0);
            st     <= S_EVAL;
            tmr    <= '0;
          end else tmr <= tmr + 32'd1;
        end
        S_EVAL: begin
          tmr <= '0;
          if (pass_q) begin
            st      <= S_UP;
            e1      <= ERR_CNT;
            PATTERN <= PAT_SEL;
            LINK_UP <= 1'b1;
          end else if (!INV) begin
            INV <= 1'b1;
            st  <= S_CLEAR;
            CLR <= 1'b1;
          end else begin
            INV       <= 1'b0;
            RETRY_CNT <= retry_nx;
            CLR       <= 1'b1;
            if (retry_nx == 4'(MAX_RETRY)) begin
              st        <= S_FAIL;
              LINK_FAIL <= 1'b1;
            end else st <= S_CLEAR;
          end
        end
        S_UP: begin
          CLR <= 1'b0;
          if (d_up > 64'(ERR_THRESH)) begin
            // Keep INV so the last good polarity is retried first.
            if (RETRAIN_CNT != 16'hFFFF) RETRAIN_CNT <= RETRAIN_CNT + 16'd1;
            LINK_UP   <= 1'b0;
            PATTERN   <= 2'd0;
            CLR       <= 1'b1;
            RETRY_CNT <= '0;
            tmr       <= '0;
            st        <= S_CLEAR;
          end else PATTERN <= PAT_SEL;
        end
        S_FAIL: begin
          CLR       <= 1'b1;
          LINK_FAIL <= 1'b1;
          if (START) begin
            st        <= S_CLEAR;
            tmr       <= '0;
            INV       <= 1'b0;
            RETRY_CNT <= '0;
            LINK_FAIL <= 1'b0;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lvds_link_ctrl.sv
// Bench for lvds_link_ctrl: an emulated lane (polarity-dependent errors, optional
// receive activity) driven against table vectors, random scenarios and corner sequences.
module tb_lvds_link_ctrl;
  localparam int CLR_C = 4, SET_C = 8, MINR = 16, TMO = 64, MAXR = 4, THR = 8;
  localparam int BUDGET = 4000;

  logic        RSTXP, CLKP, START, STOP;
  logic [1:0]  PAT_SEL;
  logic [63:0] ERR_CNT;
  logic [57:0] RECV_CNT;
  logic        CLR, INV, LINK_UP, LINK_FAIL;
  logic [1:0]  PATTERN;
  logic [2:0]  STATE;
  logic [3:0]  RETRY_CNT;
  logic [15:0] RETRAIN_CNT;

  lvds_link_ctrl #(.CLR_CYC(CLR_C), .SETTLE_CYC(SET_C), .MIN_RECV(MINR),
                   .TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR), .ERR_THRESH(THR)) dut (
    .RSTXP(RSTXP), .CLKP(CLKP), .START(START), .STOP(STOP), .PAT_SEL(PAT_SEL),
    .ERR_CNT(ERR_CNT), .RECV_CNT(RECV_CNT), .CLR(CLR), .INV(INV), .PATTERN(PATTERN),
    .LINK_UP(LINK_UP), .LINK_FAIL(LINK_FAIL), .STATE(STATE), .RETRY_CNT(RETRY_CNT),
    .RETRAIN_CNT(RETRAIN_CNT));

  initial CLKP = 1'b0;
  always #5 CLKP = ~CLKP;

  int n_cmp = 0, n_bad = 0;

  // Lane emulation: good_pol is the INV value that yields clean data (2 = never clean).
  bit lane_auto = 1'b1;
  int good_pol  = 0;
  bit recv_on   = 1'b1;
  always @(negedge CLKP) if (lane_auto) begin
    if (recv_on) RECV_CNT = RECV_CNT + 58'd1;
    if (good_pol != int'(INV)) ERR_CNT = ERR_CNT + 64'd1;
  end

  int n_clr_tot = 0;
  logic [2:0] prev_st = 3'd0;
  always @(negedge CLKP) begin
    if (STATE == 3'd1 && prev_st != 3'd1) n_clr_tot++;
    prev_st = STATE;
  end

  typedef struct {
    logic [1:0] pat; int gp; bit ron;
    bit up; bit fail; bit inv; int retry; int clears;
  } vec_t;

  task automatic step();
    @(negedge CLKP); #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Attempts alternate INV=0,1; each full pair is one sweep. The link comes up on the
  // first attempt whose polarity is clean and that sees enough words.
  function automatic vec_t predict(input logic [1:0] pat, input int gp, input bit ron);
    vec_t v;
    bit found = 1'b0;
    v.pat = pat; v.gp = gp; v.ron = ron;
    v.up = 1'b0; v.fail = 1'b1; v.inv = 1'b0; v.retry = MAXR; v.clears = 2 * MAXR;
    for (int a = 0; a < 2 * MAXR; a++) begin
      if (!found && ron && (a % 2) == gp) begin
        found = 1'b1;
        v.up = 1'b1; v.fail = 1'b0; v.inv = bit'(a % 2); v.retry = a / 2; v.clears = a + 1;
      end
    end
    return v;
  endfunction

  task automatic wait_state(input logic [2:0] s, input string nm);
    int n = 0;
    while (STATE != s && n < BUDGET) begin step(); n++; end
    if (STATE != s) chk({nm, "_timeout"}, 64'(STATE), 64'(s));
  endtask

  task automatic run_train(input logic [1:0] pat, input int gp, input bit ron,
                           output int cyc, output int clears);
    int c0;
    if (LINK_UP) begin STOP = 1'b1; step(); STOP = 1'b0; step(); end
    PAT_SEL = pat; good_pol = gp; recv_on = ron; lane_auto = 1'b1;
    c0 = n_clr_tot;
    START = 1'b1; step(); START = 1'b0;
    cyc = 0;
    while (!(LINK_UP || LINK_FAIL) && cyc < BUDGET) begin step(); cyc++; end
    if (!(LINK_UP || LINK_FAIL)) chk("train_done", 64'd0, 64'd1);
    clears = n_clr_tot - c0;
  endtask

  task automatic check_result(input vec_t v, input int clears, input string nm);
    chk({nm, "_up"},      64'(LINK_UP),   64'(v.up));
    chk({nm, "_fail"},    64'(LINK_FAIL), 64'(v.fail));
    chk({nm, "_inv"},     64'(INV),       64'(v.inv));
    chk({nm, "_retry"},   64'(RETRY_CNT), 64'(v.retry));
    chk({nm, "_state"},   64'(STATE),     v.up ? 64'd5 : 64'd6);
    chk({nm, "_clr"},     64'(CLR),       v.up ? 64'd0 : 64'd1);
    chk({nm, "_pattern"}, 64'(PATTERN),   v.up ? 64'(v.pat) : 64'd0);
    chk({nm, "_clears"},  64'(clears),    64'(v.clears));
  endtask

  vec_t tbl[5];
  vec_t v;
  int cyc, clears;
  logic [15:0] rc0;
  localparam int LAT = CLR_C + SET_C + MINR;

  initial begin
    tbl[0] = '{pat: 2'd1, gp: 0, ron: 1'b1, up: 1'b1, fail: 1'b0, inv: 1'b0, retry: 0, clears: 1};
    tbl[1] = '{pat: 2'd2, gp: 1, ron: 1'b1, up: 1'b1, fail: 1'b0, inv: 1'b1, retry: 0, clears: 2};
    tbl[2] = '{pat: 2'd3, gp: 2, ron: 1'b1, up: 1'b0, fail: 1'b1, inv: 1'b0, retry: 4, clears: 8};
    tbl[3] = '{pat: 2'd0, gp: 0, ron: 1'b0, up: 1'b0, fail: 1'b1, inv: 1'b0, retry: 4, clears: 8};
    tbl[4] = '{pat: 2'd3, gp: 0, ron: 1'b1, up: 1'b1, fail: 1'b0, inv: 1'b0, retry: 0, clears: 1};

    RSTXP = 1'b0; START = 1'b0; STOP = 1'b0; PAT_SEL = 2'd0;
    ERR_CNT = 64'd100; RECV_CNT = 58'd0;
    step(); step();
    chk("rst_state", 64'(STATE), 64'd0);
    chk("rst_clr", 64'(CLR), 64'd1);
    chk("rst_inv", 64'(INV), 64'd0);
    chk("rst_pattern", 64'(PATTERN), 64'd0);
    chk("rst_up", 64'(LINK_UP), 64'd0);
    chk("rst_fail", 64'(LINK_FAIL), 64'd0);
    chk("rst_retry", 64'(RETRY_CNT), 64'd0);
    chk("rst_retrain", 64'(RETRAIN_CNT), 64'd0);
    RSTXP = 1'b1; step();

    // Table vectors; tbl[4] follows a FAIL so it exercises START from FAIL.
    for (int i = 0; i < 5; i++) begin
      run_train(tbl[i].pat, tbl[i].gp, tbl[i].ron, cyc, clears);
      check_result(tbl[i], clears, $sformatf("tbl%0d", i));
      if (i == 0) begin
        n_cmp++;
        if (cyc < LAT || cyc > LAT + 4) begin
          n_bad++; $display("FAIL latency: got %0d want %0d..%0d", cyc, LAT, LAT + 4);
        end
      end
    end

    // Degradation while UP on an inverted lane.
    run_train(2'd1, 1, 1'b1, cyc, clears);
    chk("deg_up", 64'(LINK_UP), 64'd1);
    PAT_SEL = 2'd3; step();
    chk("deg_pat_follow", 64'(PATTERN), 64'd3);
    START = 1'b1; step(); START = 1'b0;
    chk("deg_start_ignored", 64'(STATE), 64'd5);
    lane_auto = 1'b0;
    ERR_CNT = ERR_CNT + 64'd8; step(); step(); step();
    chk("deg8_state", 64'(STATE), 64'd5);
    chk("deg8_retrain", 64'(RETRAIN_CNT), 64'd0);
    ERR_CNT = ERR_CNT + 64'd1; step();
    chk("deg9_state", 64'(STATE), 64'd1);
    chk("deg9_up", 64'(LINK_UP), 64'd0);
    chk("deg9_retrain", 64'(RETRAIN_CNT), 64'd1);
    chk("deg9_inv", 64'(INV), 64'd1);
    chk("deg9_pattern", 64'(PATTERN), 64'd0);
    chk("deg9_clr", 64'(CLR), 64'd1);
    lane_auto = 1'b1;
    wait_state(3'd5, "retrain");
    chk("retrain_inv", 64'(INV), 64'd1);
    chk("retrain_retry", 64'(RETRY_CNT), 64'd0);

    // STOP mid-UP keeps INV.
    STOP = 1'b1; step(); STOP = 1'b0;
    chk("stopup_state", 64'(STATE), 64'd0);
    chk("stopup_clr", 64'(CLR), 64'd1);
    chk("stopup_up", 64'(LINK_UP), 64'd0);
    chk("stopup_inv", 64'(INV), 64'd1);

    // STOP during MEASURE.
    good_pol = 0; START = 1'b1; step(); START = 1'b0;
    wait_state(3'd3, "to_measure");
    STOP = 1'b1; step(); STOP = 1'b0;
    chk("stopm_state", 64'(STATE), 64'd0);
    chk("stopm_clr", 64'(CLR), 64'd1);
    chk("stopm_up", 64'(LINK_UP), 64'd0);

    // Async reset mid-SETTLE: outputs must return before any clock edge.
    START = 1'b1; step(); START = 1'b0;
    wait_state(3'd2, "to_settle");
    RSTXP = 1'b0; #1;
    chk("arst_state", 64'(STATE), 64'd0);
    chk("arst_clr", 64'(CLR), 64'd1);
    chk("arst_retrain", 64'(RETRAIN_CNT), 64'd0);
    chk("arst_inv", 64'(INV), 64'd0);
    step(); RSTXP = 1'b1; step();

    // Receive counter wraps during the measurement window.
    RECV_CNT = '1; RECV_CNT = RECV_CNT - 58'd19; ERR_CNT = '1;
    run_train(2'd2, 0, 1'b1, cyc, clears);
    check_result(predict(2'd2, 0, 1'b1), clears, "wrap");
    n_cmp++;
    if (cyc > LAT + 4) begin n_bad++; $display("FAIL wrap_latency: got %0d want <=%0d", cyc, LAT + 4); end

    // Random scenarios against the behavioural model.
    for (int i = 0; i < 12; i++) begin
      logic [1:0] p;
      int g;
      bit r;
      p = 2'($urandom_range(0, 3));
      g = int'($urandom_range(0, 2));
      r = ($urandom_range(0, 3) != 0);
      RECV_CNT = {26'($urandom), 32'($urandom)};
      ERR_CNT  = {32'($urandom), 32'($urandom)};
      v = predict(p, g, r);
      rc0 = RETRAIN_CNT;
      run_train(p, g, r, cyc, clears);
      check_result(v, clears, $sformatf("rnd%0d", i));
      chk($sformatf("rnd%0d_retrain", i), 64'(RETRAIN_CNT), 64'(rc0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
